list_fetch_arbiter: RTL and testbench
=====================================

# list_fetch_arbiter

Round-robin fetch scheduler that shares one wide memory read port between up to NR list caches. It accepts refill requests (a line address) from each cache, issues one read at a time to memory, and captures the returned DBW-bit beat. It then delivers the beat to the requesting cache with bit 0 overwritten by that cache's sequence-toggle bit, so the consumer detects a new line by comparing bit 0 of the current beat against bit 0 of the previous one. It sits between the per-list caches and the shared DMA/memory read channel.

## Interface
- NR, 4, number of requesters (2..16)
- AW, 32, line address width
- DBW, 4096, line (beat) width in bits; bit 0 is reserved for the sequence toggle
- GW, $clog2(NR), grant index width
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- REQ_VALID  in  NR  refill request per requester
- REQ_ADDR  in  NR*AW  request address; requester i uses bits [i*AW +: AW]
- REQ_READY  out  NR  one-hot request acceptance pulse
- RD_ADDR  out  AW  memory read address
- RD_VALID  out  1  memory read request valid
- RD_READY  in  1  memory read request accepted
- RD_DATA  in  DBW  memory read data beat
- RD_DVALID  in  1  read data valid
- RD_DREADY  out  1  read data accepted
- LINE_DATA  out  DBW  captured line, broadcast to all requesters
- LINE_VALID  out  NR  one-hot line-valid flag for the granted requester
- LINE_READY  in  NR  per-requester line accept
- BUSY  out  1  high whenever state != IDLE
- GRANT  out  GW  index of current or last granted requester
- LINES_DONE  out  32  count of delivered lines, wraps modulo 2^32

## Operation
- FSM states: IDLE, ADDR, DATA, DELIVER.
- IDLE:
  - If any REQ_VALID is set, select g = first set bit searching upward from (last_grant+1) mod NR, wrapping round.
  - Drive REQ_READY[g]=1 combinationally in this cycle only.
  - Register addr <= REQ_ADDR[g] and GRANT <= g; go to ADDR.
  - REQ_READY is 0 in every other state.
- ADDR: RD_VALID=1 and RD_ADDR=addr, both held stable until RD_READY. On RD_READY, go to DATA.
- DATA:
  - RD_DREADY=1.
  - On RD_DVALID, register line <= {RD_DATA[DBW-1:1], ~tog[g]} and flip tog[g]; go to DELIVER.
- DELIVER:
  - LINE_VALID[g]=1 and LINE_DATA=line, both held until LINE_READY[g].
  - On LINE_READY[g]: last_grant <= g, LINES_DONE increments, go to IDLE.
  - LINE_READY on any other index is ignored.
- Per-requester toggle tog[NR], reset to 1. The first line delivered to each requester therefore carries bit 0 = 0, and bit 0 alternates on every later delivery to that requester.
- Only one read is outstanding at a time. RD_DVALID outside DATA is ignored, since RD_DREADY is 0 there.
- A requester that drops REQ_VALID before it is granted is never served; there is no request queueing.
- All state is reset together, so a late response from an aborted read is ignored as described above.

## Timing
- Reset values:
  - State IDLE.
  - REQ_READY=0, RD_VALID=0, RD_DREADY=0, LINE_VALID=0.
  - RD_ADDR=0, LINE_DATA=0, GRANT=0, BUSY=0, LINES_DONE=0.
  - tog = all ones; last_grant = NR-1, so requester 0 wins first.
- Minimum latency with RD_READY and RD_DVALID already high and LINE_READY[g] high:
  - Grant in cycle t; RD_VALID in t+1; RD_DREADY in t+2; LINE_VALID in t+3; IDLE in t+4.
  - Back-to-back grants are therefore 4 cycles apart.
- If REQ_VALID and grant fall in the same cycle, REQ_READY is a single-cycle pulse.
- RESET asserted in any state: the next cycle is IDLE with reset values. Any in-flight read is abandoned, and the memory side is reset together with this block.

## Test plan
- Single request: REQ_VALID[2]=1, addr 0x1000; memory returns a beat with bit0=1 → RD_ADDR=0x1000, LINE_VALID=4'b0100, LINE_DATA bit0=0, REQ_READY[2] pulses one cycle, LINES_DONE=1.
- Fairness: REQ_VALID=4'b1111 held for 8 fetches → grant order 0,1,2,3,0,1,2,3, each requester's bit0 sequence is 0,1.
- Backpressure: RD_READY low 5 cycles, then RD_DVALID delayed 3 cycles, LINE_READY low 4 cycles → RD_ADDR, LINE_DATA and LINE_VALID stay stable throughout, exactly one delivery results, and BUSY stays high until LINE_READY.
- Minimum latency: always-ready memory and consumer, REQ_VALID[0] constant → LINE_VALID asserted every 4 cycles starting at t+3.
- Reset mid-DATA: assert RESET while in DATA → next cycle all outputs are at reset values; the next grant goes to requester 0 and its line carries bit0=0.
- Stray signals: RD_DVALID pulsed while in ADDR, and LINE_READY[1] while granted to 3 → no state change and no extra delivery.

Source files
------------

// File: rtl/list_fetch_arbiter.sv
// list_fetch_arbiter
//   Round-robin refill scheduler sharing one wide memory read port between NR
//   list caches. One read is outstanding at a time. The returned beat is sent
//   back to the requester with bit 0 replaced by that requester's sequence
//   toggle, so the consumer can detect a new line by watching bit 0 change.
//
// Ports
//   CLK, RESET    clock; synchronous active-high reset
//   REQ_VALID     per-requester refill request
//   REQ_ADDR      per-requester line address, requester i at [i*AW +: AW]
//   REQ_READY     one-hot grant pulse (IDLE only)
//   RD_ADDR       memory read address, held while RD_VALID
//   RD_VALID      memory read request valid
//   RD_READY      memory read request accepted
//   RD_DATA       memory read data beat
//   RD_DVALID     read data valid
//   RD_DREADY     read data accepted (DATA state only)
//   LINE_DATA     captured line, broadcast to all requesters
//   LINE_VALID    one-hot line-valid for the granted requester
//   LINE_READY    per-requester line accept
//   BUSY          high whenever the scheduler is not idle
//   GRANT         index of current or last granted requester
//   LINES_DONE    delivered line count, wraps modulo 2^32
module list_fetch_arbiter #(
  parameter int NR  = 4,
  parameter int AW  = 32,
  parameter int DBW = 4096,
  parameter int GW  = $clog2(NR)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NR-1:0]     REQ_VALID,
  input  logic [NR*AW-1:0]  REQ_ADDR,
  output logic [NR-1:0]     REQ_READY,
  output logic [AW-1:0]     RD_ADDR,
  output logic              RD_VALID,
  input  logic              RD_READY,
  input  logic [DBW-1:0]    RD_DATA,
  input  logic              RD_DVALID,
  output logic              RD_DREADY,
  output logic [DBW-1:0]    LINE_DATA,
  output logic [NR-1:0]     LINE_VALID,
  input  logic [NR-1:0]     LINE_READY,
  output logic              BUSY,
  output logic [GW-1:0]     GRANT,
  output logic [31:0]       LINES_DONE
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    DATA    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [AW-1:0]   addr_r;
  logic [GW-1:0]   grant_r;
  logic [GW-1:0]   last_grant_r;
  logic [DBW-1:0]  line_r;
  logic [NR-1:0]   tog_r;
  logic [31:0]     lines_done_r;

  logic            sel_found_s;
  logic [GW-1:0]   sel_idx_s;
  logic [GW-1:0]   cand_s;

  // Bit 0 of the returned beat is always replaced by the toggle.
  logic            unused_rd_bit0_s;
  assign unused_rd_bit0_s = RD_DATA[0];

  // Round-robin pick: first requesting index above the last grant, wrapping.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    cand_s      = '0;
    for (int k = 1; k <= NR; k++) begin
      cand_s = GW'((int'(last_grant_r) + k) % NR);
      if (!sel_found_s && REQ_VALID[cand_s]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = cand_s;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Next-state logic for the fetch sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (sel_found_s) begin
          state_s = ADDR;
        end else begin
          state_s = IDLE;
        end
      end
      ADDR: begin
        if (RD_READY) begin
          state_s = DATA;
        end else begin
          state_s = ADDR;
        end
      end
      DATA: begin
        if (RD_DVALID) begin
          state_s = DELIVER;
        end else begin
          state_s = DATA;
        end
      end
      DELIVER: begin
        if (LINE_READY[grant_r]) begin
          state_s = IDLE;
        end else begin
          state_s = DELIVER;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // One-hot handshake outputs; the grant pulse only exists in IDLE.
  always_comb begin
    REQ_READY  = '0;
    LINE_VALID = '0;
    if (state_r == IDLE && sel_found_s) begin
      REQ_READY[sel_idx_s] = 1'b1;
    end else begin
      REQ_READY = '0;
    end
    if (state_r == DELIVER) begin
      LINE_VALID[grant_r] = 1'b1;
    end else begin
      LINE_VALID = '0;
    end
  end

  assign RD_VALID   = (state_r == ADDR);
  assign RD_DREADY  = (state_r == DATA);
  assign BUSY       = (state_r != IDLE);
  assign RD_ADDR    = addr_r;
  assign LINE_DATA  = line_r;
  assign GRANT      = grant_r;
  assign LINES_DONE = lines_done_r;

  // State, captured request, returned line, toggles and delivery counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r      <= IDLE;
      addr_r       <= '0;
      grant_r      <= '0;
      last_grant_r <= GW'(NR - 1);
      line_r       <= '0;
      tog_r        <= '1;
      lines_done_r <= 32'd0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (sel_found_s) begin
            addr_r  <= REQ_ADDR[int'(sel_idx_s)*AW +: AW];
            grant_r <= sel_idx_s;
          end
        end
        DATA: begin
          if (RD_DVALID) begin
            // The consumer sees a new line as a change of bit 0.
            line_r         <= {RD_DATA[DBW-1:1], ~tog_r[grant_r]};
            tog_r[grant_r] <= ~tog_r[grant_r];
          end
        end
        DELIVER: begin
          if (LINE_READY[grant_r]) begin
            last_grant_r <= grant_r;
            lines_done_r <= lines_done_r + 32'd1;
          end
        end
        default: begin
          addr_r <= addr_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_list_fetch_arbiter.sv
// Self-checking bench for list_fetch_arbiter (NR=4, AW=32, DBW=16).
module tb_list_fetch_arbiter;
  localparam int NR  = 4;
  localparam int AW  = 32;
  localparam int DBW = 16;
  localparam int GW  = 2;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [NR-1:0]     REQ_VALID;
  logic [NR*AW-1:0]  REQ_ADDR;
  logic [NR-1:0]     REQ_READY;
  logic [AW-1:0]     RD_ADDR;
  logic              RD_VALID;
  logic              RD_READY;
  logic [DBW-1:0]    RD_DATA;
  logic              RD_DVALID;
  logic              RD_DREADY;
  logic [DBW-1:0]    LINE_DATA;
  logic [NR-1:0]     LINE_VALID;
  logic [NR-1:0]     LINE_READY;
  logic              BUSY;
  logic [GW-1:0]     GRANT;
  logic [31:0]       LINES_DONE;

  list_fetch_arbiter #(.NR(NR), .AW(AW), .DBW(DBW), .GW(GW)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR), .REQ_READY(REQ_READY),
    .RD_ADDR(RD_ADDR), .RD_VALID(RD_VALID), .RD_READY(RD_READY),
    .RD_DATA(RD_DATA), .RD_DVALID(RD_DVALID), .RD_DREADY(RD_DREADY),
    .LINE_DATA(LINE_DATA), .LINE_VALID(LINE_VALID), .LINE_READY(LINE_READY),
    .BUSY(BUSY), .GRANT(GRANT), .LINES_DONE(LINES_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        rst;
    logic [3:0]  req_valid;
    logic        rd_ready;
    logic        rd_dvalid;
    logic [15:0] rd_data;
    logic [3:0]  line_ready;
  } in_t;

  typedef struct packed {
    logic [3:0]  req_ready;
    logic        rd_valid;
    logic [31:0] rd_addr;
    logic        rd_dready;
    logic [3:0]  line_valid;
    logic [15:0] line_data;
    logic        busy;
    logic [1:0]  grant;
    logic [31:0] lines_done;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state for the streaming sequences.
  int          m_last;
  logic [1:0]  m_grant;
  logic [3:0]  m_tog;
  logic [31:0] m_addr;
  logic [15:0] m_line;
  logic [31:0] m_done;

  logic [31:0] addr_tab [4] = '{32'h0000_A000, 32'h0000_B000, 32'h0000_1000, 32'h0000_D000};

  function automatic in_t mkin(input logic rst, input logic [3:0] rv, input logic rr,
                               input logic dv, input logic [15:0] dat, input logic [3:0] lr);
    in_t r;
    r.rst = rst; r.req_valid = rv; r.rd_ready = rr;
    r.rd_dvalid = dv; r.rd_data = dat; r.line_ready = lr;
    return r;
  endfunction

  function automatic out_t mkout(input logic [3:0] rq, input logic rv, input logic [31:0] ra,
                                 input logic dr, input logic [3:0] lv, input logic [15:0] ld,
                                 input logic bz, input logic [1:0] g, input logic [31:0] dn);
    out_t r;
    r.req_ready = rq; r.rd_valid = rv; r.rd_addr = ra; r.rd_dready = dr;
    r.line_valid = lv; r.line_data = ld; r.busy = bz; r.grant = g; r.lines_done = dn;
    return r;
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    tbl.push_back(v);
  endtask

  task automatic apply(input in_t i);
    RESET      = i.rst;
    REQ_VALID  = i.req_valid;
    RD_READY   = i.rd_ready;
    RD_DVALID  = i.rd_dvalid;
    RD_DATA    = i.rd_data;
    LINE_READY = i.line_ready;
  endtask

  task automatic check(input string name, input out_t e);
    out_t a;
    a = mkout(REQ_READY, RD_VALID, RD_ADDR, RD_DREADY, LINE_VALID, LINE_DATA, BUSY, GRANT, LINES_DONE);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got rq=%b rv=%b ra=%h dr=%b lv=%b ld=%h busy=%b g=%0d done=%0d, want rq=%b rv=%b ra=%h dr=%b lv=%b ld=%h busy=%b g=%0d done=%0d",
               name, a.req_ready, a.rd_valid, a.rd_addr, a.rd_dready, a.line_valid, a.line_data,
               a.busy, a.grant, a.lines_done, e.req_ready, e.rd_valid, e.rd_addr, e.rd_dready,
               e.line_valid, e.line_data, e.busy, e.grant, e.lines_done);
    end
  endtask

  // One clock cycle: drive after the falling edge, check before the rising edge.
  task automatic step(input string name, input in_t i, input out_t e);
    @(negedge CLK);
    apply(i);
    #1;
    check(name, e);
  endtask

  task automatic model_reset();
    m_last  = 3;
    m_grant = 2'd0;
    m_tog   = 4'b1111;
    m_addr  = 32'd0;
    m_line  = 16'd0;
    m_done  = 32'd0;
  endtask

  // Always-ready memory and consumer: each fetch takes exactly 4 cycles.
  task automatic run_stream(input string tag, input logic [3:0] rv, input int nfetch);
    int          g;
    logic [3:0]  oh;
    logic [15:0] beat;
    logic [15:0] exp_line;
    out_t        e;
    for (int k = 0; k < nfetch; k++) begin
      g        = (rv == 4'b0001) ? 0 : (m_last + 1) % 4;
      oh       = 4'b0001 << g;
      beat     = {8'h5A, 8'(k * 37 + int'(m_done))};
      exp_line = {beat[15:1], ~m_tog[g]};
      for (int ph = 0; ph < 4; ph++) begin
        e = mkout((ph == 0) ? oh : 4'b0000,
                  (ph == 1),
                  (ph == 0) ? m_addr : addr_tab[g],
                  (ph == 2),
                  (ph == 3) ? oh : 4'b0000,
                  (ph == 3) ? exp_line : m_line,
                  (ph != 0),
                  (ph == 0) ? m_grant : 2'(g),
                  m_done);
        step($sformatf("%s fetch%0d ph%0d", tag, k, ph),
             mkin(1'b0, rv, 1'b1, 1'b1, beat, 4'b1111), e);
      end
      m_addr  = addr_tab[g];
      m_line  = exp_line;
      m_grant = 2'(g);
      m_last  = g;
      m_done  = m_done + 32'd1;
      m_tog[g] = ~m_tog[g];
    end
  endtask

  initial begin
    REQ_ADDR = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
    apply(mkin(1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000));

    // Single request from requester 2, beat bit0=1 -> line bit0=0.
    add(mkin(0, 4'b0100, 1, 0, 16'h0000, 4'b0000), mkout(4'b0100, 0, 32'h0,    0, 4'b0000, 16'h0000, 0, 2'd0, 0));
    add(mkin(0, 4'b0000, 1, 0, 16'h0000, 4'b0000), mkout(4'b0000, 1, 32'h1000, 0, 4'b0000, 16'h0000, 1, 2'd2, 0));
    add(mkin(0, 4'b0000, 1, 1, 16'hA5A5, 4'b0000), mkout(4'b0000, 0, 32'h1000, 1, 4'b0000, 16'h0000, 1, 2'd2, 0));
    add(mkin(0, 4'b0000, 1, 0, 16'hA5A5, 4'b0100), mkout(4'b0000, 0, 32'h1000, 0, 4'b0100, 16'hA5A4, 1, 2'd2, 0));
    add(mkin(0, 4'b0000, 1, 0, 16'h0000, 4'b0000), mkout(4'b0000, 0, 32'h1000, 0, 4'b0000, 16'hA5A4, 0, 2'd2, 1));
    // Backpressure on requester 3, stray RD_DVALID in ADDR, stray LINE_READY[1].
    add(mkin(0, 4'b1010, 0, 0, 16'h0000, 4'b0000), mkout(4'b1000, 0, 32'h1000, 0, 4'b0000, 16'hA5A4, 0, 2'd2, 1));
    add(mkin(0, 4'b1010, 0, 0, 16'hFFFF, 4'b0000), mkout(4'b0000, 1, 32'hD000, 0, 4'b0000, 16'hA5A4, 1, 2'd3, 1));
    add(mkin(0, 4'b1010, 0, 1, 16'hFFFF, 4'b0000), mkout(4'b0000, 1, 32'hD000, 0, 4'b0000, 16'hA5A4, 1, 2'd3, 1));
    for (int n = 0; n < 3; n++)
      add(mkin(0, 4'b1010, 0, 0, 16'hFFFF, 4'b0000), mkout(4'b0000, 1, 32'hD000, 0, 4'b0000, 16'hA5A4, 1, 2'd3, 1));
    add(mkin(0, 4'b1010, 1, 0, 16'hFFFF, 4'b0000), mkout(4'b0000, 1, 32'hD000, 0, 4'b0000, 16'hA5A4, 1, 2'd3, 1));
    for (int n = 0; n < 3; n++)
      add(mkin(0, 4'b1010, 0, 0, 16'h1235, 4'b0000), mkout(4'b0000, 0, 32'hD000, 1, 4'b0000, 16'hA5A4, 1, 2'd3, 1));
    add(mkin(0, 4'b1010, 0, 1, 16'h1235, 4'b0000), mkout(4'b0000, 0, 32'hD000, 1, 4'b0000, 16'hA5A4, 1, 2'd3, 1));
    add(mkin(0, 4'b1010, 0, 0, 16'h0000, 4'b0010), mkout(4'b0000, 0, 32'hD000, 0, 4'b1000, 16'h1234, 1, 2'd3, 1));
    for (int n = 0; n < 3; n++)
      add(mkin(0, 4'b1010, 0, 0, 16'h0000, 4'b0000), mkout(4'b0000, 0, 32'hD000, 0, 4'b1000, 16'h1234, 1, 2'd3, 1));
    add(mkin(0, 4'b1010, 0, 0, 16'h0000, 4'b1000), mkout(4'b0000, 0, 32'hD000, 0, 4'b1000, 16'h1234, 1, 2'd3, 1));
    add(mkin(0, 4'b0000, 0, 0, 16'h0000, 4'b0000), mkout(4'b0000, 0, 32'hD000, 0, 4'b0000, 16'h1234, 0, 2'd3, 2));
    add(mkin(0, 4'b0000, 0, 0, 16'h0000, 4'b0000), mkout(4'b0000, 0, 32'hD000, 0, 4'b0000, 16'h1234, 0, 2'd3, 2));

    // Reset state.
    @(negedge CLK);
    step("reset_values", mkin(1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000),
         mkout(4'b0000, 1'b0, 32'h0, 1'b0, 4'b0000, 16'h0000, 1'b0, 2'd0, 32'd0));

    foreach (tbl[n]) begin
      step($sformatf("table[%0d]", n), tbl[n].i, tbl[n].o);
    end

    // Reset from idle, then fairness with all four requesting.
    step("pre_reset_idle", mkin(1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000),
         mkout(4'b0000, 1'b0, 32'hD000, 1'b0, 4'b0000, 16'h1234, 1'b0, 2'd3, 32'd2));
    step("reset_from_idle", mkin(1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000),
         mkout(4'b0000, 1'b0, 32'h0, 1'b0, 4'b0000, 16'h0000, 1'b0, 2'd0, 32'd0));
    model_reset();
    run_stream("fair", 4'b1111, 8);

    // Minimum latency: requester 0 alone, a fetch every 4 cycles.
    run_stream("minlat", 4'b0001, 3);

    // Reset while in DATA; a late beat afterwards must be ignored.
    step("rst_idle", mkin(1'b0, 4'b0001, 1'b1, 1'b0, 16'h0000, 4'b0000),
         mkout(4'b0001, 1'b0, m_addr, 1'b0, 4'b0000, m_line, 1'b0, m_grant, m_done));
    step("rst_addr", mkin(1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000, 4'b0000),
         mkout(4'b0000, 1'b1, 32'hA000, 1'b0, 4'b0000, m_line, 1'b1, 2'd0, m_done));
    step("rst_data", mkin(1'b1, 4'b0000, 1'b1, 1'b0, 16'h0000, 4'b0000),
         mkout(4'b0000, 1'b0, 32'hA000, 1'b1, 4'b0000, m_line, 1'b1, 2'd0, m_done));
    step("after_rst", mkin(1'b0, 4'b0000, 1'b1, 1'b1, 16'hFFFF, 4'b0000),
         mkout(4'b0000, 1'b0, 32'h0, 1'b0, 4'b0000, 16'h0000, 1'b0, 2'd0, 32'd0));
    step("late_beat_ignored", mkin(1'b0, 4'b0000, 1'b1, 1'b1, 16'hFFFF, 4'b0000),
         mkout(4'b0000, 1'b0, 32'h0, 1'b0, 4'b0000, 16'h0000, 1'b0, 2'd0, 32'd0));
    model_reset();
    run_stream("post_rst", 4'b1111, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
